// File: rtl/qbert_pkg.sv
// qbert_pkg: shared types, geometry defaults and helpers for the Q*bert hop
// controller and the pyramid renderer.
//   dir_t        move direction encoding (UL, UR, DL, DR)
//   hop_state_t  hop sequencer states (IDLE, HOP, LAND, FALL)
//   cube_idx()   flat index of cube (row,col) in the visited mask
package qbert_pkg;

  typedef enum logic [1:0] {
    UL = 2'd0,
    UR = 2'd1,
    DL = 2'd2,
    DR = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOP  = 2'd1,
    LAND = 2'd2,
    FALL = 2'd3
  } hop_state_t;

  // Geometry defaults shared by the controller and the renderers.
  localparam int X_ORIGIN_DEF = 400;
  localparam int Y_ORIGIN_DEF = 200;
  localparam int X_HALF_DEF   = 85;
  localparam int X_STEP_DEF   = 170;
  localparam int Y_STEP_DEF   = 180;

  // Cubes are numbered row by row from the apex: row r starts at r*(r+1)/2.
  function automatic int cube_idx(input logic [2:0] row, input logic [2:0] col);
    return (int'(row) * (int'(row) + 1)) / 2 + int'(col);
  endfunction

endpackage

// File: rtl/cube_coord.sv
// cube_coord: combinational map from pyramid cell (row,col) to the screen
// offset of that cube, as a 12-bit signed value.
//   row, col  in   cube cell (col <= row)
//   x, y      out  screen offset: x = X_ORIGIN + col*X_STEP - row*X_HALF,
//                                 y = Y_ORIGIN + row*Y_STEP
module cube_coord
  import qbert_pkg::*;
#(
  parameter int X_ORIGIN = X_ORIGIN_DEF,
  parameter int Y_ORIGIN = Y_ORIGIN_DEF,
  parameter int X_HALF   = X_HALF_DEF,
  parameter int X_STEP   = X_STEP_DEF,
  parameter int Y_STEP   = Y_STEP_DEF
) (
  input  logic [2:0]        row,
  input  logic [2:0]        col,
  output logic signed [11:0] x,
  output logic signed [11:0] y
);

  assign x = 12'(X_ORIGIN + int'(col) * X_STEP - int'(row) * X_HALF);
  assign y = 12'(Y_ORIGIN + int'(row) * Y_STEP);

endmodule

// File: rtl/qbert_hop_ctrl.sv
// qbert_hop_ctrl: sequences the Q*bert sprite across a triangular pyramid.
// Accepts one-hop moves over valid/ready, bounds-checks the target, animates
// the hop over 2**LOG2_HOP frames, tracks visited cubes and runs a
// fall-and-respawn sequence for moves off the pyramid.
//   clk, reset        clock, synchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   move_valid/ready  move handshake (ready only in IDLE)
//   move_dir          0=UL 1=UR 2=DL 3=DR
//   qbert_x/y         sprite screen offset
//   qbert_row/col     current cell
//   visited           per-cube landed mask, all_visited = &visited
//   done              one-cycle pulse on landing
//   fell              one-cycle pulse on respawn after a fall
// Optional feature: define QBERT_HOP_ARC_EN to lift the sprite by ARC_H over
// the middle half of each hop.
module qbert_hop_ctrl
  import qbert_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int X_ORIGIN  = X_ORIGIN_DEF,
  parameter int Y_ORIGIN  = Y_ORIGIN_DEF,
  parameter int X_HALF    = X_HALF_DEF,
  parameter int X_STEP    = X_STEP_DEF,
  parameter int Y_STEP    = Y_STEP_DEF,
  parameter int LOG2_HOP  = 3,
  parameter int FALL_STEP = 16,
  parameter int SCREEN_H  = 480,
`ifdef QBERT_HOP_ARC_EN
  parameter int ARC_H     = 40,
`endif
  localparam int NCUBES   = ROWS * (ROWS + 1) / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              move_valid,
  input  logic [1:0]        move_dir,
  output logic              move_ready,
  output logic [10:0]       qbert_x,
  output logic [9:0]        qbert_y,
  output logic [2:0]        qbert_row,
  output logic [2:0]        qbert_col,
  output logic [NCUBES-1:0] visited,
  output logic              all_visited,
  output logic              done,
  output logic              fell
);

  localparam int HOP_FRAMES = 2 ** LOG2_HOP;

  hop_state_t          state, state_next;
  logic [LOG2_HOP-1:0] k, k_next;
  logic [2:0]          row_next, col_next;
  logic [2:0]          src_row, src_col, dst_row, dst_col;
  logic [2:0]          src_row_next, src_col_next, dst_row_next, dst_col_next;
  logic [10:0]         x_next;
  logic [9:0]          y_next;
  logic [NCUBES-1:0]   visited_next;
  logic                fell_next;

  logic signed [11:0]  src_x, src_y, dst_x, dst_y;
  logic [2:0]          tgt_row, tgt_col;
  logic                tgt_ok;
  logic [10:0]         fall_sum;
  int                  x_lin, y_lin;

  cube_coord #(
    .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .X_HALF(X_HALF),
    .X_STEP(X_STEP), .Y_STEP(Y_STEP)
  ) u_src_coord (
    .row(src_row), .col(src_col), .x(src_x), .y(src_y)
  );

  cube_coord #(
    .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .X_HALF(X_HALF),
    .X_STEP(X_STEP), .Y_STEP(Y_STEP)
  ) u_dst_coord (
    .row(dst_row), .col(dst_col), .x(dst_x), .y(dst_y)
  );

  assign move_ready  = (state == IDLE);
  assign done        = (state == LAND);
  assign all_visited = &visited;
  // Widened so a fall near the bottom cannot wrap back onto the screen.
  assign fall_sum    = {1'b0, qbert_y} + 11'(FALL_STEP);

  // Target cell and legality for the requested direction.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    tgt_row = qbert_row;
    tgt_col = qbert_col;
    tgt_ok  = 1'b0;
    case (dir_t'(move_dir))
      UL: begin
        tgt_row = qbert_row - 3'd1;
        tgt_col = qbert_col - 3'd1;
        tgt_ok  = (qbert_row != 3'd0) && (qbert_col != 3'd0);
      end
      UR: begin
        tgt_row = qbert_row - 3'd1;
        tgt_ok  = (qbert_row != 3'd0) && (qbert_col < qbert_row);
      end
      DL: begin
        tgt_row = qbert_row + 3'd1;
        tgt_ok  = (int'(qbert_row) + 1 < ROWS);
      end
      DR: begin
        tgt_row = qbert_row + 3'd1;
        tgt_col = qbert_col + 3'd1;
        tgt_ok  = (int'(qbert_row) + 1 < ROWS);
      end
      default: ;
    endcase
  end

  // Interpolated position for the frame after the next tick (k+1).
  always_comb begin
    int k_inc;
    k_inc = int'(k) + 1;
    // NOTE: blocking assignments here build a chain of combinational
    // intermediates; registered state only ever uses <= in always_ff.
    x_lin = int'(src_x) + (((int'(dst_x) - int'(src_x)) * k_inc) >>> LOG2_HOP);
    y_lin = int'(src_y) + (((int'(dst_y) - int'(src_y)) * k_inc) >>> LOG2_HOP);
`ifdef QBERT_HOP_ARC_EN
    if (k_inc >= HOP_FRAMES / 4 && k_inc < 3 * HOP_FRAMES / 4) begin
      y_lin = y_lin - ARC_H;
      if (y_lin < 0) y_lin = 0;
    end
`endif
  end

  always_comb begin
    state_next   = state;
    k_next       = k;
    row_next     = qbert_row;
    col_next     = qbert_col;
    src_row_next = src_row;
    src_col_next = src_col;
    dst_row_next = dst_row;
    dst_col_next = dst_col;
    x_next       = qbert_x;
    y_next       = qbert_y;
    visited_next = visited;
    fell_next    = 1'b0;
    case (state)
      IDLE: begin
        if (move_valid) begin
          if (tgt_ok) begin
            state_next   = HOP;
            k_next       = '0;
            src_row_next = qbert_row;
            src_col_next = qbert_col;
            dst_row_next = tgt_row;
            dst_col_next = tgt_col;
          end else begin
            state_next = FALL;
          end
        end
      end
      HOP: begin
        if (frame_tick) begin
          if (int'(k) == HOP_FRAMES - 1) begin
            // Final frame snaps exactly onto the target cube.
            state_next   = LAND;
            x_next       = 11'(dst_x);
            y_next       = 10'(dst_y);
            row_next     = dst_row;
            col_next     = dst_col;
            visited_next = visited | (NCUBES'(1) << cube_idx(dst_row, dst_col));
          end else begin
            k_next = k + 1'b1;
            x_next = 11'(x_lin);
            y_next = 10'(y_lin);
          end
        end
      end
      LAND: state_next = IDLE;
      FALL: begin
        if (frame_tick) begin
          if (int'(fall_sum) >= SCREEN_H) begin
            state_next = IDLE;
            row_next   = 3'd0;
            col_next   = 3'd0;
            x_next     = 11'(X_ORIGIN);
            y_next     = 10'(Y_ORIGIN);
            fell_next  = 1'b1;
          end else begin
            y_next = fall_sum[9:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      qbert_row <= 3'd0;
      qbert_col <= 3'd0;
      src_row   <= 3'd0;
      src_col   <= 3'd0;
      dst_row   <= 3'd0;
      dst_col   <= 3'd0;
      qbert_x   <= 11'(X_ORIGIN);
      qbert_y   <= 10'(Y_ORIGIN);
      // The visited mask is a small flag register, not a memory: resetting it
      // restarts the level with only the apex coloured.
      visited   <= NCUBES'(1);
      fell      <= 1'b0;
    end else begin
      state     <= state_next;
      k         <= k_next;
      qbert_row <= row_next;
      qbert_col <= col_next;
      src_row   <= src_row_next;
      src_col   <= src_col_next;
      dst_row   <= dst_row_next;
      dst_col   <= dst_col_next;
      qbert_x   <= x_next;
      qbert_y   <= y_next;
      visited   <= visited_next;
      fell      <= fell_next;
    end
  end

endmodule

// File: tb/tb_qbert_hop_ctrl.sv
// tb_qbert_hop_ctrl: directed self-checking bench for qbert_hop_ctrl with the
// default 2-row pyramid. Inputs change and outputs are sampled on the falling
// edge of clk.
module tb_qbert_hop_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        move_ready;
  logic [10:0] qbert_x;
  logic [9:0]  qbert_y;
  logic [2:0]  qbert_row;
  logic [2:0]  qbert_col;
  logic [2:0]  visited;
  logic        all_visited;
  logic        done;
  logic        fell;

  int total = 0;
  int bad = 0;

  localparam logic [1:0] D_UL = 2'd0, D_UR = 2'd1, D_DL = 2'd2, D_DR = 2'd3;

`ifdef QBERT_HOP_ARC_EN
  localparam int Y_K4 = 250;
`else
  localparam int Y_K4 = 290;
`endif

  qbert_hop_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .qbert_x(qbert_x), .qbert_y(qbert_y), .qbert_row(qbert_row),
    .qbert_col(qbert_col), .visited(visited), .all_visited(all_visited),
    .done(done), .fell(fell)
  );

  always #5 clk = ~clk;

  // Each tick is one cycle high followed by one cycle low; on return the
  // bench sits on the falling edge right after the tick's clock edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic send_move(input logic [1:0] d);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = d;
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (qbert_x !== 11'd400) begin bad++; $display("FAIL reset_x: got %0d want 400", qbert_x); end
    total++; if (qbert_y !== 10'd200) begin bad++; $display("FAIL reset_y: got %0d want 200", qbert_y); end
    total++; if (visited !== 3'b001) begin bad++; $display("FAIL reset_visited: got %b want 001", visited); end
    total++; if (move_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", move_ready); end
    total++; if (done !== 1'b0 || fell !== 1'b0) begin bad++; $display("FAIL reset_pulses: got done=%b fell=%b want 0 0", done, fell); end
    total++; if (qbert_row !== 3'd0 || qbert_col !== 3'd0) begin bad++; $display("FAIL reset_cell: got (%0d,%0d) want (0,0)", qbert_row, qbert_col); end
  endtask

  task automatic test_hop_dr;
    send_move(D_DR);
    total++; if (move_ready !== 1'b0) begin bad++; $display("FAIL dr_ready_drop: got %b want 0", move_ready); end
    ticks(4);
    total++; if (qbert_x !== 11'd442) begin bad++; $display("FAIL dr_k4_x: got %0d want 442", qbert_x); end
    total++; if (qbert_y !== 10'(Y_K4)) begin bad++; $display("FAIL dr_k4_y: got %0d want %0d", qbert_y, Y_K4); end
    total++; if (move_ready !== 1'b0) begin bad++; $display("FAIL dr_k4_ready: got %b want 0", move_ready); end
    ticks(2);
    total++; if (qbert_x !== 11'd463 || qbert_y !== 10'd335) begin bad++; $display("FAIL dr_k6_xy: got (%0d,%0d) want (463,335)", qbert_x, qbert_y); end
    ticks(2);
    total++; if (qbert_x !== 11'd485 || qbert_y !== 10'd380) begin bad++; $display("FAIL dr_land_xy: got (%0d,%0d) want (485,380)", qbert_x, qbert_y); end
    total++; if (qbert_row !== 3'd1 || qbert_col !== 3'd1) begin bad++; $display("FAIL dr_land_cell: got (%0d,%0d) want (1,1)", qbert_row, qbert_col); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL dr_done: got %b want 1", done); end
    total++; if (visited !== 3'b101) begin bad++; $display("FAIL dr_visited: got %b want 101", visited); end
    @(negedge clk);
    total++; if (done !== 1'b0 || move_ready !== 1'b1) begin bad++; $display("FAIL dr_after_land: got done=%b ready=%b want 0 1", done, move_ready); end
  endtask

  task automatic test_hop_ul_dl;
    send_move(D_UL);
    ticks(8);
    total++; if (qbert_x !== 11'd400 || qbert_y !== 10'd200) begin bad++; $display("FAIL ul_land_xy: got (%0d,%0d) want (400,200)", qbert_x, qbert_y); end
    total++; if (qbert_row !== 3'd0 || qbert_col !== 3'd0) begin bad++; $display("FAIL ul_land_cell: got (%0d,%0d) want (0,0)", qbert_row, qbert_col); end
    total++; if (visited !== 3'b101) begin bad++; $display("FAIL ul_visited: got %b want 101", visited); end
    send_move(D_DL);
    ticks(8);
    total++; if (qbert_x !== 11'd315 || qbert_y !== 10'd380) begin bad++; $display("FAIL dl_land_xy: got (%0d,%0d) want (315,380)", qbert_x, qbert_y); end
    total++; if (visited !== 3'b111) begin bad++; $display("FAIL dl_visited: got %b want 111", visited); end
    total++; if (all_visited !== 1'b1) begin bad++; $display("FAIL dl_all_visited: got %b want 1", all_visited); end
    // Back to the apex via UR from (1,0).
    send_move(D_UR);
    ticks(8);
    total++; if (qbert_row !== 3'd0 || qbert_col !== 3'd0 || done !== 1'b1) begin bad++; $display("FAIL ur_land: got (%0d,%0d) done=%b want (0,0) done=1", qbert_row, qbert_col, done); end
  endtask

  task automatic test_fall;
    send_move(D_UL);
    total++; if (move_ready !== 1'b0 || qbert_x !== 11'd400) begin bad++; $display("FAIL fall_start: got ready=%b x=%0d want 0 400", move_ready, qbert_x); end
    ticks(17);
    total++; if (qbert_y !== 10'd472 || fell !== 1'b0) begin bad++; $display("FAIL fall_t17: got y=%0d fell=%b want 472 0", qbert_y, fell); end
    total++; if (qbert_x !== 11'd400) begin bad++; $display("FAIL fall_x_hold: got %0d want 400", qbert_x); end
    ticks(1);
    total++; if (fell !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL fall_pulse: got fell=%b done=%b want 1 0", fell, done); end
    total++; if (qbert_x !== 11'd400 || qbert_y !== 10'd200) begin bad++; $display("FAIL fall_respawn_xy: got (%0d,%0d) want (400,200)", qbert_x, qbert_y); end
    total++; if (qbert_row !== 3'd0 || qbert_col !== 3'd0) begin bad++; $display("FAIL fall_respawn_cell: got (%0d,%0d) want (0,0)", qbert_row, qbert_col); end
    total++; if (visited !== 3'b111) begin bad++; $display("FAIL fall_visited: got %b want 111", visited); end
    @(negedge clk);
    total++; if (fell !== 1'b0 || move_ready !== 1'b1) begin bad++; $display("FAIL fall_after: got fell=%b ready=%b want 0 1", fell, move_ready); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = D_DR;
    @(negedge clk);
    // Hold the request with no frame ticks: the sprite must stay put.
    repeat (5) @(negedge clk);
    total++; if (qbert_x !== 11'd400 || qbert_y !== 10'd200) begin bad++; $display("FAIL b2b_frozen: got (%0d,%0d) want (400,200)", qbert_x, qbert_y); end
    total++; if (move_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy_ready: got %b want 0", move_ready); end
    ticks(8);
    total++; if (done !== 1'b1 || qbert_row !== 3'd1 || qbert_col !== 3'd1) begin bad++; $display("FAIL b2b_land: got done=%b (%0d,%0d) want 1 (1,1)", done, qbert_row, qbert_col); end
    total++; if (move_ready !== 1'b0) begin bad++; $display("FAIL b2b_land_ready: got %b want 0", move_ready); end
    move_dir = D_UL;
    @(negedge clk);
    total++; if (move_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready: got %b want 1", move_ready); end
    @(negedge clk);
    move_valid = 1'b0;
    total++; if (move_ready !== 1'b0 || qbert_x !== 11'd485) begin bad++; $display("FAIL b2b_second_accept: got ready=%b x=%0d want 0 485", move_ready, qbert_x); end
    ticks(8);
    total++; if (qbert_row !== 3'd0 || qbert_col !== 3'd0 || done !== 1'b1) begin bad++; $display("FAIL b2b_second_land: got (%0d,%0d) done=%b want (0,0) 1", qbert_row, qbert_col, done); end
  endtask

  task automatic test_reset_mid_hop;
    send_move(D_DR);
    ticks(5);
    total++; if (qbert_x !== 11'd453 || qbert_y !== 10'd312) begin bad++; $display("FAIL mid_k5_xy: got (%0d,%0d) want (453,312)", qbert_x, qbert_y); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (qbert_x !== 11'd400 || qbert_y !== 10'd200) begin bad++; $display("FAIL mid_reset_xy: got (%0d,%0d) want (400,200)", qbert_x, qbert_y); end
    total++; if (visited !== 3'b001) begin bad++; $display("FAIL mid_reset_visited: got %b want 001", visited); end
    total++; if (move_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b want 1", move_ready); end
    // A tick in IDLE after reset must not move anything.
    ticks(1);
    total++; if (qbert_x !== 11'd400 || qbert_y !== 10'd200 || done !== 1'b0) begin bad++; $display("FAIL idle_tick: got (%0d,%0d) done=%b want (400,200) 0", qbert_x, qbert_y, done); end
  endtask

  initial begin
    test_reset();
    test_hop_dr();
    test_hop_ul_dl();
    test_fall();
    test_back_to_back();
    test_reset_mid_hop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
